// File: rtl/cpu_ifq.sv
// Instruction fetch queue between the fetch unit and decode.
// Show-ahead FIFO of {pc, instr, pred} entries. Flush empties it and opens a
// short drop window that swallows wrong-path words still coming from memory.
module cpu_ifq #(
  parameter int DEPTH    = 4,
  parameter int DROP_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_flag,
  input  logic                     in_valid,
  input  logic [15:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_pred,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [15:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_pred,
  input  logic                     out_ready,
  output logic                     wait_fetch,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
    logic        pred;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [2:0]      drop_q, drop_d;

  logic            full, empty, dropping, push, pop;
  entry_t          head;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign dropping = (drop_q != 3'd0);

  assign push = in_valid & ~full & ~flush_flag & ~dropping;
  assign pop  = ~empty & out_ready & ~flush_flag;

  // Head entry is read straight out of storage; no write-to-read bypass.
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;
  assign out_pred   = head.pred;
  assign out_valid  = ~empty;
  assign in_ready   = ~full;
  assign wait_fetch = full | dropping;
  assign count      = count_q;

  // Next-state for pointers, occupancy and drop window; flush overrides all.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = dropping ? drop_q - 3'd1 : drop_q;
    if (flush_flag) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = 3'(DROP_CYC);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; not reset since contents are ignored while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{pc: in_pc, instr: in_instr, pred: in_pred};
  end

endmodule

// File: tb/tb_cpu_ifq.sv
// Directed bench for cpu_ifq (DEPTH=4, DROP_CYC=1).
module tb_cpu_ifq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_flag, in_valid, in_pred, out_ready;
  logic [15:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, out_pred, wait_fetch;
  logic [15:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int nchk  = 0;
  int npass = 0;

  cpu_ifq #(.DEPTH(4), .DROP_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_flag(flush_flag),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_pred(in_pred),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_pred(out_pred), .out_ready(out_ready),
    .wait_fetch(wait_fetch), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = {16'hA5A5, pc};
    in_pred  = pc[2];
  endtask

  initial begin
    rst_n = 1'b0; flush_flag = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst wait_fetch", 64'(wait_fetch), 64'd0);
    chk("rst count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three pushes, decode stalled
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(4 * i));
      step();
    end
    drive(1'b0, 16'h0);
    #1;
    chk("t1 count", 64'(count), 64'd3);
    chk("t1 head pc", 64'(out_pc), 64'h0000);
    chk("t1 head instr", 64'(out_instr), 64'hA5A50000);
    chk("t1 head pred", 64'(out_pred), 64'd0);
    chk("t1 in_ready", 64'(in_ready), 64'd1);
    chk("t1 out_valid", 64'(out_valid), 64'd1);

    // 2: fill, then extra beat is refused
    drive(1'b1, 16'h000C);
    step();
    chk("t2 count", 64'(count), 64'd4);
    chk("t2 in_ready", 64'(in_ready), 64'd0);
    chk("t2 wait_fetch", 64'(wait_fetch), 64'd1);
    drive(1'b1, 16'h0010);
    step();
    chk("t2 count after 5th", 64'(count), 64'd4);
    chk("t2 head pc", 64'(out_pc), 64'h0000);

    // 3: full with pop and in_valid -> pop only, then push next cycle
    out_ready = 1'b1;
    step();
    chk("t3 count", 64'(count), 64'd3);
    chk("t3 head pc", 64'(out_pc), 64'h0004);
    out_ready = 1'b0;
    step();
    chk("t3 push accepted", 64'(count), 64'd4);

    // drain two: queue 0x4,0x8,0xC,0x10 -> 0xC,0x10
    drive(1'b0, 16'h0);
    out_ready = 1'b1;
    step(); step();
    chk("t4 pre count", 64'(count), 64'd2);

    // 4: push+pop each cycle, pointers wrap twice over
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 16'(16'h0014 + 4 * k));
      #1;
      chk($sformatf("t4 head pc %0d", k), 64'(out_pc), 64'(16'h000C + 4 * k));
      chk($sformatf("t4 head instr %0d", k), 64'(out_instr), 64'({16'hA5A5, 16'(16'h000C + 4 * k)}));
      step();
      chk($sformatf("t4 count %0d", k), 64'(count), 64'd2);
    end
    chk("t4 final head", 64'(out_pc), 64'h002C);

    // 5: count=3 then flush with in_valid
    out_ready = 1'b0;
    drive(1'b1, 16'h0034);
    step();
    chk("t5 pre count", 64'(count), 64'd3);
    flush_flag = 1'b1;
    drive(1'b1, 16'h0099);
    step();
    flush_flag = 1'b0;
    chk("t5 out_valid", 64'(out_valid), 64'd0);
    chk("t5 count", 64'(count), 64'd0);
    chk("t5 wait_fetch", 64'(wait_fetch), 64'd1);
    drive(1'b1, 16'h0077);
    step();
    chk("t5 drop count", 64'(count), 64'd0);
    chk("t5 drop out_valid", 64'(out_valid), 64'd0);
    chk("t5 drop ended", 64'(wait_fetch), 64'd0);
    drive(1'b1, 16'h0040);
    step();
    chk("t5 out_valid", 64'(out_valid), 64'd1);
    chk("t5 head pc", 64'(out_pc), 64'h0040);
    chk("t5 count after", 64'(count), 64'd1);

    // 6: async reset mid-stream
    drive(1'b1, 16'h0044);
    step();
    drive(1'b0, 16'h0);
    chk("t6 pre count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 out_valid", 64'(out_valid), 64'd0);
    chk("t6 count", 64'(count), 64'd0);
    chk("t6 in_ready", 64'(in_ready), 64'd1);
    chk("t6 wait_fetch", 64'(wait_fetch), 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
